// File: rtl/ds18b20_seq_ctrl.sv
// DS18B20 sample sequencer: drives a 1-Wire byte engine through
// reset/convert/poll/read-scratchpad and checks the scratchpad CRC-8.
module ds18b20_seq_ctrl #(
  parameter int unsigned CONV_TIMEOUT = 80_000_000,
  parameter int          PERIOD_W     = 32
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic                start,
  input  logic                auto_en,
  input  logic [PERIOD_W-1:0] period_cyc,
  output logic                cmd_valid,
  input  logic                cmd_ready,
  output logic [1:0]          cmd_op,
  output logic [7:0]          cmd_data,
  input  logic                rsp_valid,
  input  logic [7:0]          rsp_data,
  input  logic                rsp_presence,
  output logic                busy,
  output logic [15:0]         temp_raw,
  output logic                temp_valid,
  output logic                err_valid,
  output logic [1:0]          err_code,
  output logic [15:0]         sample_cnt
);

  typedef enum logic [3:0] {
    S_IDLE, S_RST1, S_SKIP1, S_CONV, S_POLL,
    S_RST2, S_SKIP2, S_RDCMD, S_RDDATA, S_CHECK
  } state_t;

  localparam logic [1:0] OP_RST = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_RD  = 2'b10;
  localparam logic [1:0] OP_BIT = 2'b11;

  state_t              state, state_n;
  logic                wt, held;
  logic [31:0]         timer;
  logic [3:0]          idx;
  logic [7:0]          crc, crc_n;
  logic [7:0]          b0, b1;
  logic [PERIOD_W-1:0] period_cnt;
  logic [PERIOD_W:0]   cnt_p1;
  logic [1:0]          op;
  logic [7:0]          dat;
  logic                is_cmd, to_hit, fire, done, trig;
  logic                end_ok, end_err;
  logic [1:0]          code_n;

  function automatic logic [7:0] crc8_byte(
    input logic [7:0] c,
    input logic [7:0] d
  );
    logic [7:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 8'h8C;
      else             r = r >> 1;
    end
    return r;
  endfunction

  always_comb begin
    op     = OP_RST;
    dat    = 8'h00;
    is_cmd = 1'b1;
    unique case (state)
      S_SKIP1, S_SKIP2: begin op = OP_WR; dat = 8'hCC; end
      S_CONV:           begin op = OP_WR; dat = 8'h44; end
      S_RDCMD:          begin op = OP_WR; dat = 8'hBE; end
      S_POLL:           op = OP_BIT;
      S_RDDATA:         op = OP_RD;
      S_IDLE, S_CHECK:  is_cmd = 1'b0;
      default:          op = OP_RST;
    endcase
    // the timeout may only cut in before a READ_BIT is presented
    to_hit = (state == S_POLL) && !wt && !held &&
             (timer >= 32'(CONV_TIMEOUT));
    cmd_valid = is_cmd && !wt && !to_hit;
    cmd_op    = cmd_valid ? op : 2'b00;
    cmd_data  = cmd_valid ? dat : 8'h00;
    fire      = cmd_valid && cmd_ready;
    done      = wt && rsp_valid;
    cnt_p1    = {1'b0, period_cnt} + (PERIOD_W+1)'(1);
    trig      = start || (auto_en && (cnt_p1 >= {1'b0, period_cyc}));
    crc_n     = crc8_byte(crc, rsp_data);
    busy      = (state != S_IDLE);
  end

  always_comb begin
    state_n = state;
    end_ok  = 1'b0;
    end_err = 1'b0;
    code_n  = err_code;
    unique case (state)
      S_IDLE: if (trig) state_n = S_RST1;
      S_RST1, S_RST2: if (done) begin
        if (!rsp_presence) begin
          state_n = S_IDLE;
          end_err = 1'b1;
          code_n  = 2'b01;
        end else begin
          state_n = (state == S_RST1) ? S_SKIP1 : S_SKIP2;
        end
      end
      S_SKIP1:  if (done) state_n = S_CONV;
      S_CONV:   if (done) state_n = S_POLL;
      S_POLL: begin
        if (to_hit) begin
          state_n = S_IDLE;
          end_err = 1'b1;
          code_n  = 2'b10;
        end else if (done && rsp_data[0]) begin
          state_n = S_RST2;
        end
      end
      S_SKIP2:  if (done) state_n = S_RDCMD;
      S_RDCMD:  if (done) state_n = S_RDDATA;
      S_RDDATA: if (done && idx == 4'd8) state_n = S_CHECK;
      S_CHECK: begin
        state_n = S_IDLE;
        if (crc == 8'h00) begin
          end_ok = 1'b1;
          code_n = 2'b00;
        end else begin
          end_err = 1'b1;
          code_n  = 2'b11;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state      <= S_IDLE;
      wt         <= 1'b0;
      held       <= 1'b0;
      timer      <= '0;
      idx        <= '0;
      crc        <= '0;
      b0         <= '0;
      b1         <= '0;
      period_cnt <= '0;
      temp_raw   <= '0;
      temp_valid <= 1'b0;
      err_valid  <= 1'b0;
      err_code   <= '0;
      sample_cnt <= '0;
    end else begin
      state <= state_n;
      held  <= cmd_valid && !cmd_ready;
      if (fire)      wt <= 1'b1;
      else if (done) wt <= 1'b0;
      if (state != S_POLL)  timer <= '0;
      else if (timer != '1) timer <= timer + 32'd1;
      if (state != S_RDDATA) idx <= '0;
      else if (done)         idx <= idx + 4'd1;
      if (state == S_RDCMD) crc <= '0;
      else if (state == S_RDDATA && done) crc <= crc_n;
      if (state == S_RDDATA && done && idx == 4'd0) b0 <= rsp_data;
      if (state == S_RDDATA && done && idx == 4'd1) b1 <= rsp_data;
      if (state == S_IDLE && trig) period_cnt <= '0;
      else if (!auto_en)           period_cnt <= '0;
      else if (period_cnt != '1)   period_cnt <= period_cnt + 1'b1;
      temp_valid <= end_ok;
      err_valid  <= end_err;
      err_code   <= code_n;
      if (end_ok) begin
        temp_raw   <= {b1, b0};
        sample_cnt <= sample_cnt + 16'd1;
      end
    end
  end

endmodule
